// File: rtl/enum_seq_pkg.sv
// Shared types for the x->y->z code sequencer: code and state enums plus the legality test.
package enum_seq_pkg;

  typedef enum logic [2:0] {
    X = 3'h1,
    Y = 3'h2,
    Z = 3'h3
  } code_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_X    = 2'd1,
    S_Y    = 2'd2,
    S_Z    = 2'd3
  } state_e;

  function automatic logic is_legal(code_e c);
    return (c == X) || (c == Y) || (c == Z);
  endfunction

endpackage

// File: rtl/enum_out_reg.sv
// One-entry valid/ready output register; a push on a full register replaces the held code
// when the consumer pops on the same edge.
module enum_out_reg (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [2:0] in_code,
  input  logic       load_en,
  output logic       in_ready,
  output logic       accept,
  output logic       out_valid,
  output logic [2:0] out_code,
  input  logic       out_ready
);

  logic load;
  logic pop;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign load     = accept && load_en;
  assign pop      = out_valid && out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out_code  <= 3'h1;
    end else if (load) begin
      out_valid <= 1'b1;
      out_code  <= in_code;
    end else if (pop) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/enum_code_sequencer.sv
// Forwards x/y/z codes through a one-entry register and counts completed x->y->z patterns.
// Optional illegal-code screening: define ENUM_SEQ_ILLEGAL_CHECK_EN.
module enum_code_sequencer
  import enum_seq_pkg::*;
#(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [2:0]       in_code,
  output logic             in_ready,
  output logic             out_valid,
  output logic [2:0]       out_code,
  input  logic             out_ready,
  output logic [1:0]       state,
  output logic             seq_done,
  output logic [CNT_W-1:0] seq_cnt,
  output logic             err
);

  state_e state_q, state_d;
  logic   done_d;
  logic   accept;
  logic   legal;
  logic   load_en;
  code_e  code;

  assign code  = code_e'(in_code);
  assign legal = is_legal(code);

`ifdef ENUM_SEQ_ILLEGAL_CHECK_EN
  assign load_en = legal;
`else
  assign load_en = 1'b1;
`endif

  enum_out_reg u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .load_en   (load_en),
    .in_ready  (in_ready),
    .accept    (accept),
    .out_valid (out_valid),
    .out_code  (out_code),
    .out_ready (out_ready)
  );

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    if (accept && legal) begin
      unique case (state_q)
        S_IDLE: state_d = (code == X) ? S_X : S_IDLE;
        S_X: begin
          if (code == X)      state_d = S_X;
          else if (code == Y) state_d = S_Y;
          else                state_d = S_IDLE;
        end
        S_Y: begin
          if (code == Z) begin
            state_d = S_Z;
            done_d  = 1'b1;
          end else if (code == X) begin
            state_d = S_X;
          end else begin
            state_d = S_IDLE;
          end
        end
        S_Z:     state_d = (code == X) ? S_X : S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
`ifndef ENUM_SEQ_ILLEGAL_CHECK_EN
    else if (accept) begin
      state_d = S_IDLE;
    end
`endif
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      seq_done <= 1'b0;
      seq_cnt  <= '0;
    end else begin
      state_q  <= state_d;
      seq_done <= done_d;
      if (done_d) seq_cnt <= seq_cnt + CNT_W'(1);
    end
  end

  assign state = state_q;

`ifdef ENUM_SEQ_ILLEGAL_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= accept && !legal;
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_enum_code_sequencer.sv
// Directed bench for enum_code_sequencer with a reference model feeding an expected-result queue.
module tb_enum_code_sequencer;

  localparam int unsigned CNT_W = 2;
`ifdef ENUM_SEQ_ILLEGAL_CHECK_EN
  localparam bit CHECK = 1'b1;
`else
  localparam bit CHECK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic [2:0]       in_code;
  logic             in_ready;
  logic             out_valid;
  logic [2:0]       out_code;
  logic             out_ready;
  logic [1:0]       state;
  logic             seq_done;
  logic [CNT_W-1:0] seq_cnt;
  logic             err;

  enum_code_sequencer #(.CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_code   (in_code),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_code  (out_code),
    .out_ready (out_ready),
    .state     (state),
    .seq_done  (seq_done),
    .seq_cnt   (seq_cnt),
    .err       (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic             valid;
    logic [2:0]       code;
    logic [1:0]       st;
    logic [CNT_W-1:0] cnt;
    logic             done;
    logic             err;
  } exp_t;

  exp_t sb[$];

  int errors = 0;
  int checks = 0;
  int done_seen = 0;

  logic             m_valid;
  logic [2:0]       m_code;
  logic [1:0]       m_state;
  logic [CNT_W-1:0] m_cnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pattern tracker written from the transition table: x always restarts, y only advances from S_X,
  // z only completes from S_Y.
  function automatic logic [1:0] nxt(input logic [1:0] s, input logic [2:0] c);
    if (c == 3'h1) return 2'd1;
    if (c == 3'h2) return (s == 2'd1) ? 2'd2 : 2'd0;
    return (s == 2'd2) ? 2'd3 : 2'd0;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_code  = 3'h1;
    m_state = 2'd0;
    m_cnt   = '0;
    sb.delete();
  endtask

  task automatic step(input logic v, input logic [2:0] c, input logic r);
    exp_t e, got;
    logic rdy, acc, legal;
    in_valid  = v;
    in_code   = c;
    out_ready = r;
    #1;
    rdy = !m_valid || r;
    chk("in_ready", in_ready, rdy);
    acc   = v && rdy;
    legal = (c >= 3'h1) && (c <= 3'h3);
    e.done = acc && legal && (m_state == 2'd2) && (c == 3'h3);
    e.err  = acc && !legal && CHECK;
    if (acc && (legal || !CHECK)) begin
      m_valid = 1'b1;
      m_code  = c;
    end else if (m_valid && r) begin
      m_valid = 1'b0;
    end
    if (acc && legal)       m_state = nxt(m_state, c);
    else if (acc && !CHECK) m_state = 2'd0;
    if (e.done) m_cnt = m_cnt + 1'b1;
    e.valid = m_valid;
    e.code  = m_code;
    e.st    = m_state;
    e.cnt   = m_cnt;
    sb.push_back(e);
    @(posedge clk);
    #1;
    got = sb.pop_front();
    chk("out_valid", out_valid, got.valid);
    if (got.valid) chk("out_code", out_code, got.code);
    chk("state", state, got.st);
    chk("seq_done", seq_done, got.done);
    chk("seq_cnt", seq_cnt, got.cnt);
    chk("err", err, got.err);
    if (seq_done === 1'b1) done_seen++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    in_code = 3'h0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_code", out_code, 3'h1);
    chk("rst_state", state, 2'd0);
    chk("rst_seq_cnt", seq_cnt, '0);
    chk("rst_seq_done", seq_done, 1'b0);
    chk("rst_err", err, 1'b0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    do_reset();

    // Complete sequence, one code per cycle
    step(1, 3'h1, 1);
    step(1, 3'h2, 1);
    step(1, 3'h3, 1);
    chk("seq1_state", state, 2'd3);
    chk("seq1_cnt", seq_cnt, 2'd1);
    step(0, 3'h0, 1);
    chk("seq1_done_pulses", done_seen, 1);

    // Out-of-order restart
    done_seen = 0;
    step(1, 3'h1, 1);
    step(1, 3'h3, 1);
    chk("ooo_state_after_z", state, 2'd0);
    step(1, 3'h1, 1);
    step(1, 3'h2, 1);
    step(1, 3'h3, 1);
    step(0, 3'h0, 1);
    chk("ooo_done_pulses", done_seen, 1);
    chk("ooo_cnt", seq_cnt, 2'd2);

    // Backpressure: hold, blocked push, then pop+push replacement
    step(1, 3'h1, 1);
    step(0, 3'h0, 0);
    step(1, 3'h2, 0);
    chk("bp_held_code", out_code, 3'h1);
    step(1, 3'h3, 1);
    chk("bp_replaced", out_code, 3'h3);
    step(0, 3'h0, 1);

    // Illegal codes from S_X, with and without a same-edge pop
    step(1, 3'h1, 1);
    step(1, 3'h5, 1);
    step(0, 3'h0, 0);
    step(1, 3'h1, 0);
    step(1, 3'h7, 1);
    step(1, 3'h0, 1);
    step(0, 3'h0, 1);

    // Counter wrap at CNT_W=2
    do_reset();
    for (int unsigned i = 0; i < 4; i++) begin
      step(1, 3'h1, 1);
      step(1, 3'h2, 1);
      step(1, 3'h3, 1);
      chk("wrap_cnt", seq_cnt, CNT_W'(i + 1));
    end

    // Asynchronous reset while in S_Y
    step(1, 3'h1, 1);
    step(1, 3'h2, 1);
    chk("pre_rst_state", state, 2'd2);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_state", state, 2'd0);
    chk("async_rst_cnt", seq_cnt, '0);
    chk("async_rst_valid", out_valid, 1'b0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    step(1, 3'h3, 1);
    step(0, 3'h0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enum_code_sequencer.md
# enum_code_sequencer

Downstream consumer of the 3-bit enum code stream (`x`=3'h1, `y`=3'h2, `z`=3'h3) produced by the enum-driving stage. It accepts codes over a valid/ready handshake and forwards legal codes through a one-entry output register. It tracks the ordered pattern x→y→z with an enum-typed FSM, pulses on each completed pattern, and counts completions. Illegal-code screening is optional at compile time.

## Interface
- `CNT_W`, default 8: width of the completed-sequence counter.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `in_valid` input 1: upstream code valid.
- `in_code` input 3: upstream code (`code_e`).
- `in_ready` output 1: block can accept a code.
- `out_valid` output 1: output register holds a code.
- `out_code` output 3: forwarded code (`code_e`).
- `out_ready` input 1: downstream accepts the code.
- `state` output 2: current FSM state (`state_e`).
- `seq_done` output 1: one-cycle pulse on each completed x→y→z.
- `seq_cnt` output CNT_W: completed-sequence count.
- `err` output 1: one-cycle pulse on an illegal code (only when screening is compiled in).

## Operation
- Handshake:
  - `in_ready = !out_valid || out_ready`, purely combinational.
  - A code is accepted on a rising edge when `in_valid && in_ready`.
- Output register:
  - An accepted legal code loads `out_code` and sets `out_valid`.
  - `out_valid` clears when `out_valid && out_ready` and nothing is loaded on the same edge.
  - Simultaneous pop and push while full: the new code replaces the old one, and `out_valid` stays 1.
- Legal codes are x, y, z. All other values (0, 4–7) are illegal.
- FSM states (`state_e`): S_IDLE=0, S_X=1, S_Y=2, S_Z=3. Transitions on an accepted legal code:
  - S_IDLE: x→S_X; y or z→S_IDLE.
  - S_X: x→S_X; y→S_Y; z→S_IDLE.
  - S_Y: z→S_Z and completion; x→S_X; y→S_IDLE.
  - S_Z: x→S_X; y or z→S_IDLE.
- Completion:
  - `seq_done` is 1 for exactly one cycle.
  - `seq_cnt` increments by 1 on the same edge, modulo 2^CNT_W (wraps from all-ones to 0).
- Cycles with no accepted code leave the FSM, counter and pulses unchanged (pulses return to 0).
- Reset values, applied asynchronously while `rst` is high:
  - `out_valid`=0, `out_code`=3'h1 (x), `state`=S_IDLE, `seq_done`=0, `seq_cnt`=0, `err`=0.
  - Reset mid-sequence discards partial progress and any held code.

## Timing
- Accept to `out_valid`/`out_code` visible: 1 cycle (registered).
- Accept of completing z to `seq_done`=1 and new `seq_cnt`: 1 cycle.
- Accept of illegal code to `err`=1: 1 cycle.
- Throughput: one code per cycle while `out_ready` is held high.
- `in_ready` depends combinationally on `out_ready`; there is no combinational path from `in_*` to `out_*`.

## Configuration
- Macro: `ENUM_SEQ_ILLEGAL_CHECK_EN`.
- Defined:
  - An accepted illegal code completes the input handshake but is not loaded into the output register.
  - The FSM state is unchanged, and `err` pulses 1 cycle later.
  - If the register was popped on the same edge, `out_valid` falls.
- Undefined:
  - Every accepted code is forwarded unchanged.
  - An illegal code sends the FSM to S_IDLE.
  - `err` is tied to 0.

## Structure
- Package `enum_seq_pkg`:
  - `typedef enum logic [2:0] code_e {X=3'h1, Y=3'h2, Z=3'h3}`.
  - `typedef enum logic [1:0] state_e`.
  - Function `is_legal(code_e)`.
- One sub-module, `enum_out_reg`: the one-entry valid/ready output register, which generates `in_ready`. The FSM and counter stay in the top.

## Test plan
- Reset check: assert `rst` for 2 cycles with `in_valid`=0 → `out_valid`=0, `out_code`=3'h1, `state`=0, `seq_cnt`=0, `err`=0.
- Complete sequence: stream 1,2,3 with `out_ready`=1 → `out_code` shows 1,2,3 on consecutive cycles; `seq_done` pulses once; `seq_cnt`=1; `state`=3.
- Out-of-order restart: stream 1,3,1,2,3 → exactly one `seq_done`; state trace 1,0,1,2,3; `seq_cnt`=1.
- Backpressure: `out_ready`=0 after one accepted code → `in_ready`=0 and the held code is stable; raise `out_ready` together with `in_valid` → replacement code is loaded and `out_valid` stays 1.
- Illegal code, with the macro: state S_X, send 5 → `err` pulses, `out_valid` unchanged/falls per pop, `state` stays 1. Without the macro: `out_code`=5, `state`=0, `err`=0.
- Wrap and reset: with `CNT_W`=2, run 4 sequences → `seq_cnt` reads 1,2,3,0; assert `rst` while in S_Y → `state`=0 immediately and `seq_cnt`=0.
